sine_period_meter: RTL
======================

Name: sine_period_meter

Overview:
- Downstream consumer of the 16-bit signed sine-table stream (LUT sample generator).
- Detects rising zero crossings and measures period length in accepted samples, plus max, min and peak-to-peak amplitude per period.
- Presents one result per completed period on a valid/ready handshake.
- Used as on-chip self-check of the sine source and as a generic tone meter.

Parameters:
- DW, 16, input sample width (signed two's complement).
- PW, 8, period counter / result width; max measurable period = 2**PW-1 samples.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  sample strobe; in_data accepted on a cycle when high.
- in_data  in  DW  signed input sample.
- clr  in  1  synchronous clear of sticky status bits.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_period  out  PW  samples between consecutive rising crossings.
- res_max  out  DW  signed maximum in period.
- res_min  out  DW  signed minimum in period.
- res_p2p  out  DW+1  unsigned res_max - res_min.
- locked  out  1  high while in MEAS state.
- status  out  2  sticky: bit0 overrun, bit1 timeout.

Behaviour:
- Reset values: res_valid=0, res_period=0, res_max=0, res_min=0, res_p2p=0, locked=0, status=0, state=SEEK, prev_valid=0, cnt=0.
- Only accepted samples (in_valid=1) affect state. With in_valid=0, all registers hold.
- Rising crossing on an accepted sample: prev_valid=1, prev<0, cur>=0 (signed compare). prev and prev_valid update on every accepted sample.
- SEEK:
  - On crossing: go to MEAS, cnt=1, max=min=cur.
  - Otherwise stay in SEEK.
- MEAS, on an accepted sample:
  - Crossing: emit result (period=cnt, max, min, p2p computed from pre-update max/min; the crossing sample is excluded). Then cnt=1, max=min=cur, stay in MEAS.
  - Non-crossing with cnt=2**PW-1: timeout. Set status[1], go to SEEK, no result.
  - Otherwise: cnt+1, max=max(max,cur), min=min(min,cur).
- Emit timing: output registers load and res_valid=1 on the cycle after the crossing sample is accepted (1-cycle latency).
- Handshake:
  - Outputs are stable while res_valid=1 and res_ready=0.
  - Transfer occurs when res_valid & res_ready; res_valid drops next cycle unless a new emit happens in the same cycle.
  - Emit while res_valid=1 & res_ready=0: new result is dropped, held result unchanged, status[0] set.
  - Emit while res_valid=1 & res_ready=1: new result loaded, res_valid stays 1, no overrun.
- p2p arithmetic: computed in DW+1 bits, never wraps. Range 0..2**DW-1.
- status bits:
  - Sticky until clr=1 or rst.
  - If clr and a set event occur in the same cycle, the set wins.
- Reset mid-operation: all state returns to reset values immediately. Any pending result is discarded, and the first period after reset is never reported; the meter re-enters SEEK.
- Priority: rst > everything; emit/timeout computed before clr.

Test Plan:
- Continuous 15-sample LUT stream (0,14217,25619,31946,31946,25619,14217,0,-14217,-25619,-31946,-31946,-25619,-14217,0) from rst release, res_ready=1 -> first crossing at sample 14, first res_valid on cycle 30. Every 15 cycles after: period=15, max=31946, min=-31946, p2p=63892. status=0, locked=1 from cycle 15.
- Same stream with in_valid toggling every other cycle -> results identical (period=15), res_valid spacing 30 cycles.
- res_ready=0 held for 40 cycles -> first result held unchanged, status=01 after second emit. Assert clr -> status=00. Raise res_ready -> the original first result transfers.
- Constant +100 after one crossing (-5 then +100 stream), PW=8 -> after 255 counted samples, locked=0, status=10, no result emitted.
- Assert rst for 1 cycle mid-period (cycle 22) of LUT stream -> outputs zero next cycle. Next res_valid occurs 2 crossings later, period=15.
- Crossing with res_valid=1 and res_ready=1 in the same cycle -> res_valid stays 1, new values loaded, status[0]=0.

Source files
------------

// File: rtl/sine_period_meter_if.sv
// Sample/result bundle for the sine period meter.
//
// Signals:
//   in_valid    sample strobe, in_data is taken on a cycle when high
//   in_data     signed input sample
//   res_valid   result available
//   res_ready   consumer accepts the result
//   res_period  accepted samples between consecutive rising crossings
//   res_max     signed maximum seen in the period
//   res_min     signed minimum seen in the period
//   res_p2p     unsigned res_max - res_min
//
// Modports: master drives samples and consumes results (source/consumer
// side); slave is the meter itself.
interface sine_period_meter_if #(
    parameter int DW = 16,
    parameter int PW = 8
);
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 res_valid;
    logic                 res_ready;
    logic [PW-1:0]        res_period;
    logic signed [DW-1:0] res_max;
    logic signed [DW-1:0] res_min;
    logic [DW:0]          res_p2p;

    modport master (
        output in_valid, in_data, res_ready,
        input  res_valid, res_period, res_max, res_min, res_p2p
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output res_valid, res_period, res_max, res_min, res_p2p
    );
endinterface

// File: rtl/sine_period_meter.sv
// Sine period meter: finds rising zero crossings in a signed sample stream
// and reports, once per completed period, the period length in accepted
// samples together with the signed max, min and peak-to-peak amplitude.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   clr_i     synchronous clear of the sticky status bits
//   locked_o  high while a period is being measured
//   status_o  sticky flags: bit0 result overrun, bit1 period timeout
//   bus       sample input and result valid/ready output (slave side)
module sine_period_meter #(
    parameter int DW = 16,
    parameter int PW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    output logic               locked_o,
    output logic [1:0]         status_o,
    sine_period_meter_if.slave bus
);

    typedef enum logic {SEEK = 1'b0, MEAS = 1'b1} state_t;

    localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    // Peak-to-peak in DW+1 bits so a full-scale swing cannot wrap.
    function automatic logic [DW:0] p2p_calc(input logic signed [DW-1:0] hi,
                                             input logic signed [DW-1:0] lo);
        logic signed [DW:0] hi_x;
        logic signed [DW:0] lo_x;
        logic signed [DW:0] diff;
        hi_x = (DW+1)'(hi);
        lo_x = (DW+1)'(lo);
        diff = hi_x - lo_x;
        return $unsigned(diff);
    endfunction

    // Control state
    state_t        state_q, state_d;
    logic          prev_valid_q, prev_valid_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          res_valid_q, res_valid_d;
    logic [1:0]    status_q, status_d;

    // Datapath state
    logic signed [DW-1:0] prev_q, prev_d;
    logic signed [DW-1:0] max_q, max_d;
    logic signed [DW-1:0] min_q, min_d;
    logic [PW-1:0]        res_period_q, res_period_d;
    logic signed [DW-1:0] res_max_q, res_max_d;
    logic signed [DW-1:0] res_min_q, res_min_d;
    logic [DW:0]          res_p2p_q, res_p2p_d;

    logic signed [DW-1:0] cur;
    logic                 crossing;
    logic                 emit;
    logic                 timeout;
    logic                 overrun;

    assign cur = bus.in_data;

    always_comb begin
        state_d      = state_q;
        prev_valid_d = prev_valid_q;
        prev_d       = prev_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        min_d        = min_q;
        res_valid_d  = res_valid_q;
        res_period_d = res_period_q;
        res_max_d    = res_max_q;
        res_min_d    = res_min_q;
        res_p2p_d    = res_p2p_q;
        status_d     = status_q;
        emit         = 1'b0;
        timeout      = 1'b0;
        overrun      = 1'b0;

        // prev < 0 and cur >= 0 reduce to the two sign bits.
        crossing = bus.in_valid && prev_valid_q && prev_q[DW-1] && !cur[DW-1];

        if (bus.in_valid) begin
            prev_d       = cur;
            prev_valid_d = 1'b1;
            unique case (state_q)
                SEEK: begin
                    if (crossing) begin
                        state_d = MEAS;
                        cnt_d   = CNT_ONE;
                        max_d   = cur;
                        min_d   = cur;
                    end
                end
                MEAS: begin
                    if (crossing) begin
                        // Result uses the pre-update window; the crossing
                        // sample opens the next period instead.
                        emit  = 1'b1;
                        cnt_d = CNT_ONE;
                        max_d = cur;
                        min_d = cur;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout = 1'b1;
                        state_d = SEEK;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cur > max_q) max_d = cur;
                        if (cur < min_q) min_d = cur;
                    end
                end
                default: state_d = SEEK;
            endcase
        end

        // A new result may only replace the held one if it is leaving
        // this very cycle; otherwise the new one is dropped.
        if (emit) begin
            if (!res_valid_q || bus.res_ready) begin
                res_valid_d  = 1'b1;
                res_period_d = cnt_q;
                res_max_d    = max_q;
                res_min_d    = min_q;
                res_p2p_d    = p2p_calc(max_q, min_q);
            end else begin
                overrun = 1'b1;
            end
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_d = 1'b0;
        end

        // Clear first so a same-cycle set event survives.
        if (clr_i) status_d = 2'b00;
        status_d = status_d | {timeout, overrun};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEEK;
            prev_valid_q <= 1'b0;
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_period_q <= '0;
            res_max_q    <= '0;
            res_min_q    <= '0;
            res_p2p_q    <= '0;
            status_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            prev_valid_q <= prev_valid_d;
            cnt_q        <= cnt_d;
            res_valid_q  <= res_valid_d;
            res_period_q <= res_period_d;
            res_max_q    <= res_max_d;
            res_min_q    <= res_min_d;
            res_p2p_q    <= res_p2p_d;
            status_q     <= status_d;
        end
    end

    // Running window values are qualified by state/prev_valid, so they
    // need no reset.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        max_q  <= max_d;
        min_q  <= min_d;
    end

    assign bus.res_valid  = res_valid_q;
    assign bus.res_period = res_period_q;
    assign bus.res_max    = res_max_q;
    assign bus.res_min    = res_min_q;
    assign bus.res_p2p    = res_p2p_q;
    assign locked_o       = (state_q == MEAS);
    assign status_o       = status_q;

endmodule
